// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer.
// Contents: instruction field positions, opcode encodings and the
// sequencer state encoding. The sequencer and its decoder import this
// package.
package program_sequencer_pkg;

  // Instruction word layout: {opcode[7:4], ra[3:2], rb[1:0]}
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RA_HI  = 3;
  localparam int RA_LO  = 2;
  localparam int RB_HI  = 1;
  localparam int RB_LO  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_PUSH = 4'b1000,
    OP_LDA  = 4'b1001,
    OP_LDB  = 4'b1010,
    OP_OUT  = 4'b1011,
    OP_BSHL = 4'b1100,
    OP_BSHR = 4'b1101
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT_ALU,
    ST_DONE
  } state_e;

endpackage

// File: rtl/program_sequencer_seq_decode.sv
// Combinational instruction classifier.
// Ports:
//   ir                    in  8  instruction word
//   is_alu .. is_out      out 1  instruction class flags (exactly one set)
//   is_nop                out 1  1110, 1111 and any unprogrammed (X/Z) word
module program_sequencer_seq_decode
  import program_sequencer_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_alu,
  output logic       is_push,
  output logic       is_lda,
  output logic       is_ldb,
  output logic       is_out,
  output logic       is_nop
);

  // NOTE: every output gets a default before the case so no path through
  // this block leaves one unassigned; that is what keeps it free of latches.
  always_comb begin
    is_alu  = 1'b0;
    is_push = 1'b0;
    is_lda  = 1'b0;
    is_ldb  = 1'b0;
    is_out  = 1'b0;
    is_nop  = 1'b0;
    case (ir[OPC_HI:OPC_LO])
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR,
      OP_BSHL, OP_BSHR: is_alu  = 1'b1;
      OP_PUSH:          is_push = 1'b1;
      OP_LDA:           is_lda  = 1'b1;
      OP_LDB:           is_ldb  = 1'b1;
      OP_OUT:           is_out  = 1'b1;
      // An X/Z opcode matches no item above and lands here as a NOP.
      default:          is_nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute controller for the 8-bit processor.
// Selects one of four ROM programs, walks the ROM address, decodes each
// instruction and issues one-cycle strobes to the register file and ALU,
// waiting on alu_valid (with a timeout) after each ALU launch.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   start, prog_sel      begin a run of program prog_sel (IDLE only)
//   abort                synchronous return to IDLE from any busy state
//   rom_prog, rom_addr   ROM program select and program counter
//   rom_instr            combinational ROM data
//   alu_op, alu_go       ALU opcode and one-cycle launch pulse
//   alu_valid            ALU result ready
//   reg_a, reg_b         register fields of the current instruction
//   load_a, load_b       one-cycle register load pulses
//   push_en, out_en      one-cycle push / output pulses
//   busy, done, error    status: not idle, run-end pulse, sticky error
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MAX_ADDR    = 255,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              abort,
  output logic [1:0]        rom_prog,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_instr,
  output logic [3:0]        alu_op,
  output logic              alu_go,
  input  logic              alu_valid,
  output logic [1:0]        reg_a,
  output logic [1:0]        reg_b,
  output logic              load_a,
  output logic              load_b,
  output logic              push_en,
  output logic              out_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int                TIMER_W    = $clog2(ALU_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(MAX_ADDR);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ALU_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [1:0]          prog_q, prog_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                error_q, error_d;
  logic                advance;
  logic                is_alu, is_push, is_lda, is_ldb, is_out, is_nop;

  program_sequencer_seq_decode u_seq_decode (
    .ir      (ir_q),
    .is_alu  (is_alu),
    .is_push (is_push),
    .is_lda  (is_lda),
    .is_ldb  (is_ldb),
    .is_out  (is_out),
    .is_nop  (is_nop)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      prog_q  <= '0;
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      prog_q  <= prog_d;
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    prog_d  = prog_q;
    timer_d = timer_q;
    error_d = error_q;
    advance = 1'b0;
    alu_go  = 1'b0;
    alu_op  = 4'h0;
    push_en = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    out_en  = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prog_d  = prog_sel;
          pc_d    = '0;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = rom_instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_go  = is_alu;
        push_en = is_push;
        load_a  = is_lda;
        load_b  = is_ldb;
        out_en  = is_out;
        if (is_alu) begin
          alu_op  = ir_q[OPC_HI:OPC_LO];
          timer_d = '0;
          state_d = ST_WAIT_ALU;
        end else if (is_out) begin
          state_d = ST_DONE;
        end else begin
          advance = is_push | is_lda | is_ldb | is_nop;
        end
      end
      ST_WAIT_ALU: begin
        // A result on the last allowed cycle still wins over the timeout.
        if (alu_valid) begin
          advance = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Step to the next instruction; the program counter never wraps, so
    // finishing the last address without an out is a run-off error.
    if (advance) begin
      if (pc_q == LAST_PC) begin
        error_d = 1'b1;
        state_d = ST_DONE;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = ST_FETCH;
      end
    end

    // Abort overrides everything outside IDLE: no strobes, no done pulse,
    // error left as it was. In IDLE a simultaneous start is honoured.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pc_d    = pc_q;
      ir_d    = ir_q;
      prog_d  = prog_q;
      timer_d = timer_q;
      error_d = error_q;
      alu_go  = 1'b0;
      alu_op  = 4'h0;
      push_en = 1'b0;
      load_a  = 1'b0;
      load_b  = 1'b0;
      out_en  = 1'b0;
      done    = 1'b0;
    end
  end

  assign rom_prog = prog_q;
  assign rom_addr = pc_q;
  assign busy     = (state_q != ST_IDLE);
  assign error    = error_q;
  assign reg_a    = (state_q == ST_EXEC || state_q == ST_WAIT_ALU) ? ir_q[RA_HI:RA_LO] : 2'b00;
  assign reg_b    = (state_q == ST_EXEC || state_q == ST_WAIT_ALU) ? ir_q[RB_HI:RB_LO] : 2'b00;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam int ALU_TIMEOUT = 16;
  localparam int MAX_ADDR    = 255;
  localparam int NEVER       = 99;   // responder delay meaning "never answer"

  typedef struct packed {
    logic [2:0] kind;   // 1 alu, 2 push, 3 lda, 4 ldb, 5 out
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] addr;
  } ev_t;

  typedef struct {
    logic [1:0] prog;
    int         dly;
    int         exp_busy;
    logic       exp_err;
    int         exp_nev;
  } vec_t;

  logic       clk, reset, start, abort, alu_valid;
  logic [1:0] prog_sel, rom_prog, reg_a, reg_b;
  logic [7:0] rom_addr, rom_instr;
  logic [3:0] alu_op;
  logic       alu_go, load_a, load_b, push_en, out_en, busy, done, error;

  logic [7:0] rom [4][256];
  int         dly [256];
  int         dly_q [$];
  ev_t        got_q [$], exp_q [$];
  ev_t        mon_ev;
  int         n_checks, n_errors, done_cnt;

  assign rom_instr = rom[rom_prog][rom_addr];

  program_sequencer #(.ADDR_W(8), .MAX_ADDR(MAX_ADDR), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .abort(abort),
    .rom_prog(rom_prog), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .alu_op(alu_op), .alu_go(alu_go), .alu_valid(alu_valid),
    .reg_a(reg_a), .reg_b(reg_b), .load_a(load_a), .load_b(load_b),
    .push_en(push_en), .out_en(out_en), .busy(busy), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Event monitor: logs every strobe cycle and counts done pulses.
  always @(negedge clk) begin
    if (!reset && (alu_go || push_en || load_a || load_b || out_en)) begin
      check("strobe_onehot", 64'($countones({alu_go, push_en, load_a, load_b, out_en})), 64'd1);
      mon_ev.kind = alu_go ? 3'd1 : push_en ? 3'd2 : load_a ? 3'd3 : load_b ? 3'd4 : 3'd5;
      mon_ev.op   = alu_go ? alu_op : 4'h0;
      mon_ev.ra   = reg_a;
      mon_ev.rb   = reg_b;
      mon_ev.addr = rom_addr;
      got_q.push_back(mon_ev);
    end
    if (!reset && done) done_cnt++;
  end

  // ALU responder: answers each alu_go after the next queued delay.
  initial begin
    int d;
    alu_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && alu_go) begin
        d = (dly_q.size() > 0) ? dly_q.pop_front() : NEVER;
        if (d <= ALU_TIMEOUT) begin
          repeat (d) @(negedge clk);
          alu_valid = 1'b1;
          @(negedge clk);
          alu_valid = 1'b0;
        end
      end
    end
  end

  // Reference model: walks the program instruction by instruction and
  // totals the busy cycles (2 per instruction, plus the ALU wait, plus DONE).
  task automatic model_run(input int p, output int cyc, output logic err);
    int pc, k;
    logic fin;
    logic [7:0] ins;
    logic [3:0] op;
    ev_t e;
    exp_q.delete();
    pc = 0; k = 0; cyc = 0; err = 1'b0; fin = 1'b0;
    while (!fin) begin
      ins    = rom[p][pc];
      op     = ins[7:4];
      cyc   += 2;
      e.kind = 3'd0;
      e.op   = 4'h0;
      e.ra   = ins[3:2];
      e.rb   = ins[1:0];
      e.addr = 8'(pc);
      if (op == 4'hB) begin
        e.kind = 3'd5;
        exp_q.push_back(e);
        fin = 1'b1;
      end else begin
        if (op <= 4'd7 || op == 4'hC || op == 4'hD) begin
          e.kind = 3'd1;
          e.op   = op;
          if (dly[k] > ALU_TIMEOUT) begin
            cyc += ALU_TIMEOUT;
            err  = 1'b1;
            fin  = 1'b1;
          end else begin
            cyc += dly[k];
          end
          k++;
        end else if (op == 4'h8) e.kind = 3'd2;
        else if (op == 4'h9) e.kind = 3'd3;
        else if (op == 4'hA) e.kind = 3'd4;
        if (e.kind != 3'd0) exp_q.push_back(e);
        if (!fin) begin
          if (pc == MAX_ADDR) begin
            err = 1'b1;
            fin = 1'b1;
          end else begin
            pc++;
          end
        end
      end
    end
    cyc += 1;
  endtask

  task automatic run_prog(input logic [1:0] p, output int ncyc);
    int guard;
    got_q.delete();
    done_cnt = 0;
    prog_sel = p;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncyc  = 0;
    guard = 0;
    while (busy && guard < 6000) begin
      ncyc++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 6000) check("run_bound", 64'(guard), 64'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 6000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 6000) check("idle_bound", 64'(guard), 64'd0);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nev"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_ev"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  function automatic logic [7:0] rand_word(input logic allow_out);
    int r, a;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    a = $urandom_range(0, 9);
    if (r < 2)       op = allow_out ? 4'hB : 4'hE;
    else if (r < 40) op = (a < 8) ? 4'(a) : 4'(a + 4);
    else if (r < 55) op = 4'h8;
    else if (r < 70) op = 4'h9;
    else if (r < 85) op = 4'hA;
    else             op = 4'(14 + $urandom_range(0, 1));
    return {op, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    vec_t vecs[5];
    int   ncyc, mcyc;
    logic merr;

    n_checks = 0; n_errors = 0; done_cnt = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; prog_sel = 2'b00;

    vecs[0] = '{2'd1, 1,     5,  1'b0, 2};
    vecs[1] = '{2'd0, 1,     19, 1'b0, 7};
    vecs[2] = '{2'd3, 3,     24, 1'b0, 7};
    vecs[3] = '{2'd2, NEVER, 19, 1'b1, 1};
    vecs[4] = '{2'd0, 16,    49, 1'b0, 7};

    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 256; a++) rom[p][a] = 8'hF0;
    rom[0][0] = 8'h90; rom[0][1] = 8'hA4; rom[0][2] = 8'h21; rom[0][3] = 8'h80;
    rom[0][4] = 8'h51; rom[0][5] = 8'h80; rom[0][6] = 8'hE0; rom[0][7] = 8'hB0;
    rom[1][0] = 8'h98; rom[1][1] = 8'hB0;
    rom[2][0] = 8'h10;
    rom[3][0] = 8'h60; rom[3][1] = 8'h80; rom[3][2] = 8'h64; rom[3][3] = 8'h84;
    rom[3][4] = 8'h00; rom[3][5] = 8'h80; rom[3][6] = 8'hB0;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({busy, done, error, alu_go, push_en, load_a, load_b, out_en,
               reg_a, reg_b, rom_addr, rom_prog, alu_op}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Program 1, cycle by cycle from the start edge.
    prog_sel = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t1_c1_load_a", 64'(load_a), 64'd0);
    @(negedge clk);
    check("t1_c2_load_a", 64'(load_a), 64'd1);
    repeat (2) @(negedge clk);
    check("t1_c4_out_en", 64'(out_en), 64'd1);
    check("t1_c4_reg_a", 64'(reg_a), 64'd0);
    @(negedge clk);
    check("t1_c5_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t1_c6_busy", 64'(busy), 64'd0);
    check("t1_c6_error", 64'(error), 64'd0);

    // Table of whole-program runs.
    foreach (vecs[i]) begin
      for (int a = 0; a < 256; a++) dly[a] = vecs[i].dly;
      dly_q.delete();
      for (int a = 0; a < 16; a++) dly_q.push_back(vecs[i].dly);
      model_run(int'(vecs[i].prog), mcyc, merr);
      run_prog(vecs[i].prog, ncyc);
      check($sformatf("vec%0d_busy_cycles", i), 64'(ncyc), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_done_pulses", i), 64'(done_cnt), 64'd1);
      check($sformatf("vec%0d_event_count", i), 64'(got_q.size()), 64'(vecs[i].exp_nev));
      compare_events($sformatf("vec%0d", i));
    end

    // Timeout: error lands exactly after 16 WAIT_ALU cycles; next start clears it.
    dly_q.delete();
    prog_sel = 2'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("to_c2_alu_go", 64'(alu_go), 64'd1);
    repeat (16) @(negedge clk);
    check("to_c18_state", 64'({busy, done, error}), 64'b100);
    @(negedge clk);
    check("to_c19_state", 64'({busy, done, error}), 64'b111);
    @(negedge clk);
    check("to_c20_state", 64'({busy, done, error}), 64'b001);
    prog_sel = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("to_restart_error", 64'(error), 64'd0);
    wait_idle();

    // Abort together with alu_valid; a start while busy is ignored.
    dly_q.delete();
    dly_q.push_back(2);
    done_cnt = 0;
    prog_sel = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    prog_sel = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ab_c4_rom_prog", 64'(rom_prog), 64'd0);
    check("ab_c4_rom_addr", 64'(rom_addr), 64'd1);
    check("ab_c4_load_b", 64'(load_b), 64'd1);
    repeat (2) @(negedge clk);
    check("ab_c6_alu", 64'({alu_go, alu_op, reg_a, reg_b}), 64'h1_2_1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_c9_busy_done", 64'({busy, done}), 64'd0);
    @(negedge clk);
    check("ab_c10_push_done", 64'({push_en, done, busy}), 64'd0);
    check("ab_done_pulses", 64'(done_cnt), 64'd0);
    check("ab_error", 64'(error), 64'd0);

    // Abort and start together in IDLE: start wins.
    prog_sel = 2'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abst_busy_prog", 64'({busy, rom_prog}), 64'b101);
    wait_idle();

    // Asynchronous reset in the middle of FETCH.
    prog_sel = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_addr", 64'(rom_addr), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_outputs",
          64'({busy, done, error, alu_go, push_en, load_a, load_b, out_en,
               reg_a, reg_b, rom_addr, rom_prog, alu_op}), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 256; a++) dly[a] = 1;
    dly_q.delete();
    model_run(1, mcyc, merr);
    run_prog(2'd1, ncyc);
    check("rst_restart_cycles", 64'(ncyc), 64'd5);
    compare_events("rst_restart");

    // Randomized programs and ALU latencies against the model.
    for (int r = 0; r < 40; r++) begin
      int   p, mode, q;
      p    = $urandom_range(0, 3);
      mode = r % 4;
      for (int a = 0; a < 256; a++) begin
        rom[p][a] = rand_word(mode != 0);
        q = $urandom_range(0, 99);
        if (mode == 1 && q < 2)      dly[a] = NEVER;
        else if (mode >= 2 && q < 4) dly[a] = ALU_TIMEOUT;
        else                         dly[a] = $urandom_range(1, 4);
      end
      dly_q.delete();
      for (int a = 0; a < 256; a++) dly_q.push_back(dly[a]);
      model_run(p, mcyc, merr);
      run_prog(2'(p), ncyc);
      check($sformatf("rnd%0d_busy_cycles", r), 64'(ncyc), 64'(mcyc));
      check($sformatf("rnd%0d_error", r), 64'(error), 64'(merr));
      check($sformatf("rnd%0d_done_pulses", r), 64'(done_cnt), 64'd1);
      compare_events($sformatf("rnd%0d", r));
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Fetch/execute controller for the 8-bit processor. It selects one of four ROM programs, walks the ROM address, and decodes each 8-bit instruction ({opcode[7:4], ra[3:2], rb[1:0]}). It drives one-cycle control strobes into the register file and ALU, and waits on a ready handshake for ALU operations. It sits between the top-level start/program-select controls and the eight-bit ROM plus datapath.

Parameters:
ADDR_W, 8, ROM address width
MAX_ADDR, 255, last legal ROM address; executing at MAX_ADDR without reaching out ends the run with error
ALU_TIMEOUT, 16, cycles allowed in WAIT_ALU before error abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a program; sampled only in IDLE
prog_sel  in  2  program number; latched on accepted start
abort  in  1  synchronous abort; any state except IDLE goes to IDLE next edge
rom_prog  out  2  latched program number to ROM
rom_addr  out  ADDR_W  program counter to ROM
rom_instr  in  8  combinational ROM data
alu_op  out  4  opcode to ALU; valid while alu_go=1
alu_go  out  1  one-cycle ALU launch pulse
alu_valid  in  1  ALU result ready; may assert 1..N cycles after alu_go
reg_a  out  2  ra field of current instruction
reg_b  out  2  rb field of current instruction
load_a  out  1  one-cycle pulse for lda
load_b  out  1  one-cycle pulse for ldb
push_en  out  1  one-cycle pulse for push; write the ALU result into reg_a
out_en  out  1  one-cycle pulse for out; present reg_a
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run end
error  out  1  sticky; set on timeout or run-off; cleared by the next accepted start

Behaviour:
- Reset values: state=IDLE, pc=0, ir=0, prog_q=0, timer=0. All strobes, busy, done and error are 0. rom_prog=0, rom_addr=0.
- States: IDLE, FETCH, EXEC, WAIT_ALU, DONE.
- IDLE: on start=1, latch prog_q<=prog_sel, pc<=0, error<=0, then go to FETCH. start while busy is ignored.
- FETCH: rom_addr=pc, ir<=rom_instr, then go to EXEC.
- EXEC: decodes ir; exactly one strobe is high for this single cycle.
  - Opcodes 0000-0111, 1100, 1101: alu_go=1, alu_op=ir[7:4], timer<=0, then go to WAIT_ALU.
  - 1000: push_en=1.
  - 1001: load_a=1.
  - 1010: load_b=1.
  - 1011: out_en=1, then go to DONE.
  - 1110, 1111, and X/Z (unprogrammed ROM words): NOP.
  - All non-out, non-ALU cases: if pc==MAX_ADDR, set error and go to DONE; otherwise pc<=pc+1 and go to FETCH.
- WAIT_ALU: on alu_valid=1, advance pc as above and go to FETCH. Otherwise timer increments; at timer==ALU_TIMEOUT-1 without valid, set error and go to DONE. alu_valid outside WAIT_ALU is ignored.
- DONE: done=1 for one cycle, then go to IDLE.
- reg_a/reg_b are driven from ir[3:2]/ir[1:0] in EXEC and WAIT_ALU; 0 otherwise.
- Latency: start edge to first EXEC is 2 cycles. Non-ALU instructions take 2 cycles each. ALU instructions take 2 cycles plus the wait for valid.
- pc never wraps past MAX_ADDR.
- abort has priority over every transition including alu_valid. It clears strobes and goes to IDLE without pulsing done. error is unchanged.
- reset mid-run: immediate return to the reset state.
- Simultaneous abort and start in IDLE: start is accepted.

Decomposition:
- Shared package: opcode constants (add..bshr, push, lda, ldb, out), instruction field positions, and the state encoding.
- One natural sub-module: seq_decode, a combinational ir-to-{is_alu, is_push, is_lda, is_ldb, is_out, is_nop} classifier. It is reused by the datapath assertions.

Test Plan:
- prog_sel=01, start pulse: load_a on cycle 2, out_en on cycle 4 with reg_a=00, done on cycle 5, busy low on cycle 6, error=0.
- prog_sel=00, ALU valid 1 cycle after alu_go: strobe sequence is lda, ldb, alu_go(op=0010, reg_a=00, reg_b=01), push, alu_go(op=0101), push, NOP at address 6, out. done follows; pc never exceeds 7.
- prog_sel=11, valid 3 cycles after each alu_go: alu_op sequence is 0110, 0110, 0000. push_en reg_a sequence is 00, 01, 00. out_en fires and done pulses.
- alu_valid held low, ALU_TIMEOUT=16: error=1 exactly 16 cycles into WAIT_ALU, then done pulse, then IDLE. The next start clears error.
- abort asserted during WAIT_ALU, together with alu_valid: IDLE next cycle, no done, no push_en. A start during busy is ignored.
- reset asserted asynchronously mid-FETCH: all outputs go to 0 before the next clock edge, and the sequencer restarts cleanly on the next start.
